dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single data memory port between the core LSU (priority requester) and a debug/program-loader port.
It issues at most one access per cycle, returns read data with one-cycle latency tagged to the requester that issued it, and guarantees debug forward progress through a starvation counter.
Debug can hold a multi-beat lock for bulk loads.
It sits between the LSU/debug master and the dmem instance.

Parameters:
ADDR_W, 11, memory word-byte address width presented to dmem
DATA_W, 32, data width
STARVE_MAX, 4, consecutive denied debug cycles before debug is force-granted (range 1..15)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous active-high reset
i_c_req  in  1  core access request
i_c_we  in  1  core write enable (1=store, 0=load)
i_c_addr  in  ADDR_W  core address
i_c_wdata  in  DATA_W  core store data
i_c_be  in  4  core byte enables
o_c_gnt  out  1  core access issued this cycle
o_c_rvalid  out  1  core read data valid
o_c_rdata  out  DATA_W  core read data
i_d_req  in  1  debug access request
i_d_we  in  1  debug write enable
i_d_lock  in  1  debug requests grant hold for following beats
i_d_addr  in  ADDR_W  debug address
i_d_wdata  in  DATA_W  debug store data
i_d_be  in  4  debug byte enables
o_d_gnt  out  1  debug access issued this cycle
o_d_rvalid  out  1  debug read data valid
o_d_rdata  out  DATA_W  debug read data
o_m_addr  out  ADDR_W  to dmem
o_m_wdata  out  DATA_W  to dmem
o_m_be  out  4  to dmem
o_m_wren  out  1  to dmem write strobe
i_m_rdata  in  DATA_W  dmem read data, valid one cycle after address
o_c_stall  out  1  i_c_req & ~o_c_gnt, for PC hold

Behaviour:
- Reset (async, any cycle): state=ARB, starve_cnt=0, both rvalid=0. Any read in flight is discarded; no rvalid pulses after reset release for it.
- States: ARB (normal priority), DBG_LOCK (debug owns port).
- Grant in ARB: force = (starve_cnt == STARVE_MAX). If i_d_req & force, grant debug. Else if i_c_req, grant core. Else if i_d_req, grant debug. Else no grant.
- Grant in DBG_LOCK: debug granted if i_d_req; core never granted.
- Transitions:
  - ARB->DBG_LOCK when debug is granted and i_d_lock=1.
  - DBG_LOCK stays while i_d_req & i_d_lock.
  - DBG_LOCK->ARB when i_d_req=0 or i_d_lock=0. A beat with lock=0 is still granted, then the state returns to ARB.
- Grants are combinational and same-cycle. Exactly one or zero of o_c_gnt/o_d_gnt is high; never both.
- Memory mux: o_m_* driven from the granted requester. o_m_wren = gnt & we. With no grant, o_m_addr/wdata/be = 0 and o_m_wren = 0.
- Read return: o_x_rvalid is registered, = (x_gnt & ~x_we) from the previous cycle. o_x_rdata = i_m_rdata when o_x_rvalid, else 0. Writes produce no rvalid.
- Back-to-back reads by alternating requesters each get their own rvalid on consecutive cycles.
- starve_cnt (registered):
  - Cleared when o_d_gnt=1 or i_d_req=0.
  - Incremented, saturating at STARVE_MAX, when i_d_req & ~o_d_gnt.
  - A force grant takes effect in the cycle the count equals STARVE_MAX.
- Requests are level-sensitive. A denied requester holds req and payload stable until granted; the arbiter stores no payload.
- Simultaneous requests with starve_cnt < STARVE_MAX in ARB: core wins, and o_c_stall=0.
- o_c_stall is high whenever the core request is denied, including every cycle in DBG_LOCK.

Test Plan:
- Core only: i_c_req=1, read addr 0x010 with mem word 0xDEADBEEF -> o_c_gnt=1 same cycle, o_m_addr=0x010, o_m_wren=0; next cycle o_c_rvalid=1, o_c_rdata=0xDEADBEEF, o_d_rvalid=0.
- Contention with starvation, STARVE_MAX=4: core and debug requesting continuously -> core granted cycles 0-3, debug granted cycle 4, core cycle 5; starve_cnt sequence 1,2,3,4,0,1; o_c_stall=1 only at cycle 4.
- Debug locked burst: debug writes 3 beats with i_d_lock=1, then a 4th beat with lock=0, while core requests -> o_d_gnt for 4 consecutive cycles, o_m_wren=1 each beat, o_c_stall=1 for all 4; core granted on the 5th cycle.
- Alternating reads: core read at cycle N, debug read at N+1 -> o_c_rvalid at N+1 only, o_d_rvalid at N+2 only, each carrying its own address's data.
- Write has no return: core store be=4'b0011, wdata=0x1234 -> o_m_wren=1, o_m_be=4'b0011 for one cycle; no rvalid next cycle.
- Reset mid-read: assert i_reset asynchronously in the cycle after a debug read grant, mid-clock -> o_d_rvalid drops to 0 immediately; state ARB and starve_cnt=0 after release; first post-reset core request is granted without delay.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter (core priority, debug lock, starvation guard)
// Read data returns one cycle after issue, tagged to the requester that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  input  logic [3:0]        i_c_be,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic              i_d_lock,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [3:0]        i_d_be,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  output logic [3:0]        o_m_be,
  output logic              o_m_wren,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic              o_c_stall
);

  typedef enum logic {ARB, DBG_LOCK} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic       c_gnt, d_gnt, force_dbg;
  logic       c_rvalid_q, d_rvalid_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      c_rvalid_q <= c_gnt & ~i_c_we;
      d_rvalid_q <= d_gnt & ~i_d_we;
    end
  end

  always_comb begin
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    state_next = state;
    force_dbg  = (starve_cnt == STARVE_LIM);
    case (state)
      ARB: begin
        if (i_d_req && force_dbg) d_gnt = 1'b1;
        else if (i_c_req)         c_gnt = 1'b1;
        else if (i_d_req)         d_gnt = 1'b1;
        if (d_gnt && i_d_lock) state_next = DBG_LOCK;
      end
      DBG_LOCK: begin
        // The final beat (lock dropped) is still granted before returning to ARB.
        d_gnt = i_d_req;
        if (!(i_d_req && i_d_lock)) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (d_gnt || !i_d_req)           starve_next = 4'd0;
    else if (starve_cnt != STARVE_LIM) starve_next = starve_cnt + 4'd1;
  end

  always_comb begin
    o_m_addr  = '0;
    o_m_wdata = '0;
    o_m_be    = 4'b0000;
    o_m_wren  = 1'b0;
    if (c_gnt) begin
      o_m_addr  = i_c_addr;
      o_m_wdata = i_c_wdata;
      o_m_be    = i_c_be;
      o_m_wren  = i_c_we;
    end else if (d_gnt) begin
      o_m_addr  = i_d_addr;
      o_m_wdata = i_d_wdata;
      o_m_be    = i_d_be;
      o_m_wren  = i_d_we;
    end
  end

  assign o_c_gnt    = c_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_c_stall  = i_c_req & ~c_gnt;
  assign o_c_rvalid = c_rvalid_q;
  assign o_d_rvalid = d_rvalid_q;
  assign o_c_rdata  = c_rvalid_q ? i_m_rdata : '0;
  assign o_d_rdata  = d_rvalid_q ? i_m_rdata : '0;

endmodule
